// File: rtl/fft_frame_sequencer.sv
// Ping-pong frame collector feeding the FFT core as gap-free bursts, then
// indexing the returned spectrum bins. Raises a sticky flag on dropped frames.
module fft_frame_sequencer #(
  parameter int LOG2N = 10,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_strobe,
  input  logic             fft_ready,
  input  logic             fft_source_valid,
  input  logic             clear_overrun,
  output logic             fft_sink_valid,
  output logic             fft_sink_sop,
  output logic             fft_sink_eop,
  output logic [WIDTH-1:0] fft_sink_data,
  output logic             bin_valid,
  output logic [LOG2N-1:0] bin_addr,
  output logic             frame_done,
  output logic             busy,
  output logic             overrun
);
  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, WAIT_READY, STREAM, CAPTURE} state_t;

  logic [WIDTH-1:0] r_mem [2*N];
  logic [WIDTH-1:0] r_ram_q;
  state_t           r_state;
  logic [LOG2N-1:0] r_wr_ptr;
  logic [LOG2N-1:0] r_rd_ptr;
  logic [LOG2N-1:0] r_bin_cnt;
  logic [LOG2N-1:0] r_bin_addr;
  logic             r_fill_bank;
  logic             r_pending;
  logic             r_sink_valid;
  logic             r_sink_sop;
  logic             r_sink_eop;
  logic             r_bin_valid;
  logic             r_frame_done;
  logic             r_busy;
  logic             r_overrun;
  logic             w_fill_done;
  logic             w_accept;

  assign w_fill_done = sample_strobe && (r_wr_ptr == LAST);
  // The streamer always owns the bank not being filled, so a completed frame
  // may only flip banks once the previous frame has left the buffer.
  assign w_accept    = !r_pending && (r_state != STREAM);

  always_ff @(posedge clk) begin
    if (reset && sample_strobe) begin
      r_mem[{r_fill_bank, r_wr_ptr}] <= sample_in;
    end
    r_ram_q <= r_mem[{~r_fill_bank, r_rd_ptr}];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_bin_cnt    <= '0;
      r_bin_addr   <= '0;
      r_fill_bank  <= 1'b0;
      r_pending    <= 1'b0;
      r_sink_valid <= 1'b0;
      r_sink_sop   <= 1'b0;
      r_sink_eop   <= 1'b0;
      r_bin_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (sample_strobe) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_fill_done && w_accept) begin
        r_fill_bank <= ~r_fill_bank;
      end
      if (clear_overrun) begin
        r_overrun <= 1'b0;
      end else if (w_fill_done && !w_accept) begin
        r_overrun <= 1'b1;
      end

      r_bin_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_busy <= r_pending;
          if (r_pending) begin
            r_state  <= WAIT_READY;
            r_rd_ptr <= '0;
          end
        end
        WAIT_READY: begin
          if (fft_ready) begin
            r_state      <= STREAM;
            r_pending    <= 1'b0;
            r_rd_ptr     <= r_rd_ptr + 1'b1;
            r_sink_valid <= 1'b1;
            r_sink_sop   <= 1'b1;
            r_sink_eop   <= (r_rd_ptr == LAST);
          end
        end
        STREAM: begin
          // r_rd_ptr runs one address ahead of the beat on the output.
          if (r_sink_eop) begin
            r_state      <= CAPTURE;
            r_sink_valid <= 1'b0;
            r_sink_eop   <= 1'b0;
            r_sink_sop   <= 1'b0;
            r_bin_cnt    <= '0;
          end else begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_sink_sop <= 1'b0;
            r_sink_eop <= (r_rd_ptr == LAST);
          end
        end
        CAPTURE: begin
          if (fft_source_valid) begin
            r_bin_valid <= 1'b1;
            r_bin_addr  <= r_bin_cnt;
            r_bin_cnt   <= r_bin_cnt + 1'b1;
            if (r_bin_cnt == LAST) begin
              r_frame_done <= 1'b1;
              r_state      <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_fill_done && w_accept) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign fft_sink_valid = r_sink_valid;
  assign fft_sink_sop   = r_sink_sop;
  assign fft_sink_eop   = r_sink_eop;
  assign fft_sink_data  = r_sink_valid ? r_ram_q : '0;
  assign bin_valid      = r_bin_valid;
  assign bin_addr       = r_bin_addr;
  assign frame_done     = r_frame_done;
  assign busy           = r_busy;
  assign overrun        = r_overrun;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer with N = 8: directed vectors,
// multi-cycle corner sequences and a randomized run against a frame-level model.
module tb_fft_frame_sequencer;
  localparam int LOG2N = 3;
  localparam int N     = 8;
  localparam int W     = 18;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] sample_in = '0;
  logic         sample_strobe = 1'b0;
  logic         fft_ready = 1'b0;
  logic         fft_source_valid = 1'b0;
  logic         clear_overrun = 1'b0;
  logic         fft_sink_valid, fft_sink_sop, fft_sink_eop;
  logic [W-1:0] fft_sink_data;
  logic         bin_valid;
  logic [LOG2N-1:0] bin_addr;
  logic         frame_done, busy, overrun;

  always #5 clk = ~clk;

  fft_frame_sequencer #(.LOG2N(LOG2N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_strobe(sample_strobe),
    .fft_ready(fft_ready), .fft_source_valid(fft_source_valid), .clear_overrun(clear_overrun),
    .fft_sink_valid(fft_sink_valid), .fft_sink_sop(fft_sink_sop), .fft_sink_eop(fft_sink_eop),
    .fft_sink_data(fft_sink_data), .bin_valid(bin_valid), .bin_addr(bin_addr),
    .frame_done(frame_done), .busy(busy), .overrun(overrun)
  );

  typedef struct packed {
    logic v, sop, eop;
    logic [W-1:0] d;
    logic bv;
    logic [LOG2N-1:0] ba;
    logic fd, busy, ovr;
  } outs_t;

  typedef struct {
    logic         strobe;
    logic [W-1:0] sample;
    logic         ready;
    logic         srcv;
    outs_t        exp;
  } vec_t;

  outs_t obs;
  assign obs = {fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_data,
                bin_valid, bin_addr, frame_done, busy, overrun};

  int n_cmp = 0;
  int n_err = 0;
  vec_t tbl[41];

  // Frame-level reference: modes follow the named streamer phases, frames are
  // copied into a queue when accepted and consumed beat by beat.
  bit    model_on = 0;
  int    m_mode;   // 0 idle, 1 waiting for ready, 2 streaming, 3 capturing
  int    m_fill;
  int    m_frame[N];
  bit    m_pending;
  int    m_q[$];
  int    m_beat;
  int    m_bins;
  outs_t m_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input outs_t exp);
    outs_t a, e;
    a = obs;
    e = exp;
    if (!e.bv) begin
      a.ba = '0;
      e.ba = '0;
    end
    chk(name, 32'(a), 32'(e));
  endtask

  function automatic void model_reset();
    m_mode = 0; m_fill = 0; m_pending = 0; m_beat = 0; m_bins = 0;
    m_q.delete();
    m_exp = '0;
  endfunction

  function automatic void model_step();
    outs_t e;
    bit set_pend, clr_pend, drop;
    e = '0;
    e.ovr = m_exp.ovr;
    e.ba  = m_exp.ba;
    set_pend = 0; clr_pend = 0; drop = 0;
    if (sample_strobe) begin
      m_frame[m_fill] = int'(sample_in);
      if (m_fill == N - 1) begin
        if (!m_pending && m_mode != 2) begin
          set_pend = 1;
          foreach (m_frame[i]) m_q.push_back(m_frame[i]);
        end else begin
          drop = 1;
        end
      end
      m_fill = (m_fill + 1) % N;
    end
    case (m_mode)
      0: if (m_pending) m_mode = 1;
      1: if (fft_ready) begin
        m_mode = 2; clr_pend = 1;
        e.v = 1; e.sop = 1; e.eop = (N == 1); e.d = W'(m_q[0]);
        m_beat = 1;
      end
      2: if (m_beat == N) begin
        m_mode = 3; m_bins = 0;
        repeat (N) void'(m_q.pop_front());
      end else begin
        e.v = 1; e.eop = (m_beat == N - 1); e.d = W'(m_q[m_beat]);
        m_beat++;
      end
      default: if (fft_source_valid) begin
        e.bv = 1; e.ba = 3'(m_bins);
        if (m_bins == N - 1) begin
          e.fd = 1; m_mode = 0;
        end
        m_bins++;
      end
    endcase
    m_pending = (m_pending && !clr_pend) || set_pend;
    if (clear_overrun) e.ovr = 0;
    else if (drop)     e.ovr = 1;
    e.busy = (m_mode != 0) || e.fd;
    m_exp = e;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (model_on) model_step();
    @(negedge clk);
  endtask

  task automatic fill_frame(input int base);
    for (int i = 0; i < N; i++) begin
      sample_strobe = 1'b1;
      sample_in = W'(base + i + 1);
      tick();
    end
    sample_strobe = 1'b0;
  endtask

  task automatic expect_burst(input string name, input int base);
    fft_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      tick();
      fft_ready = 1'b0;
      chk($sformatf("%s_ctl%0d", name, k), {fft_sink_valid, fft_sink_sop, fft_sink_eop},
          {1'b1, k == 0, k == N - 1});
      chk($sformatf("%s_data%0d", name, k), 32'(fft_sink_data), 32'(base + k + 1));
    end
    tick();
    chk($sformatf("%s_after", name), 32'(fft_sink_valid), 32'd0);
  endtask

  task automatic capture_all(input string name, input int gap);
    for (int k = 0; k < N; k++) begin
      fft_source_valid = 1'b1;
      tick();
      fft_source_valid = 1'b0;
      chk($sformatf("%s_bin%0d", name, k), {bin_valid, bin_addr, frame_done, busy},
          {1'b1, 3'(k), k == N - 1, 1'b1});
      repeat (gap) tick();
    end
    tick();
    chk($sformatf("%s_idle", name), {bin_valid, busy}, 2'b00);
  endtask

  initial begin
    // Directed frame + capture table, one row per clock edge.
    for (int r = 0; r < 41; r++) begin
      tbl[r].strobe = 1'b0;
      tbl[r].sample = '0;
      tbl[r].ready  = 1'b1;
      tbl[r].srcv   = 1'b0;
      tbl[r].exp    = '0;
      if (r < 8) begin
        tbl[r].strobe = 1'b1;
        tbl[r].sample = W'(r + 1);
      end
      if (r >= 8 && r <= 39) tbl[r].exp.busy = 1'b1;
      if (r >= 9 && r <= 16) begin
        tbl[r].exp.v   = 1'b1;
        tbl[r].exp.d   = W'(r - 8);
        tbl[r].exp.sop = (r == 9);
        tbl[r].exp.eop = (r == 16);
      end
      if (r >= 18 && r <= 39 && (r - 18) % 3 == 0) begin
        tbl[r].srcv   = 1'b1;
        tbl[r].exp.bv = 1'b1;
        tbl[r].exp.ba = 3'((r - 18) / 3);
        tbl[r].exp.fd = (r == 39);
      end
    end

    // Reset held with strobes active.
    reset = 1'b0; sample_strobe = 1'b1; sample_in = 18'h3FFFF; fft_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_outs($sformatf("reset%0d", i), '0);
    end
    reset = 1'b1; sample_strobe = 1'b0;

    for (int r = 0; r < 41; r++) begin
      sample_strobe    = tbl[r].strobe;
      sample_in        = tbl[r].sample;
      fft_ready        = tbl[r].ready;
      fft_source_valid = tbl[r].srcv;
      tick();
      chk_outs($sformatf("basic[%0d]", r), tbl[r].exp);
    end
    sample_strobe = 1'b0; fft_source_valid = 1'b0; fft_ready = 1'b0;

    // Ready stall for 20 cycles in WAIT_READY.
    fill_frame(32'h100);
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("stall%0d", i), {fft_sink_valid, busy}, 2'b01);
    end
    expect_burst("stall_burst", 32'h100);
    capture_all("stall_cap", 0);

    // Two back-to-back frames with no ready: the second is dropped.
    for (int i = 0; i < 16; i++) begin
      sample_strobe = 1'b1;
      sample_in = W'(32'h200 + i + 1);
      tick();
      if (i == 14) chk("ovr_before", 32'(overrun), 32'd0);
    end
    sample_strobe = 1'b0;
    chk("ovr_set", 32'(overrun), 32'd1);
    repeat (3) tick();
    chk("ovr_held", 32'(overrun), 32'd1);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("ovr_clear", 32'(overrun), 32'd0);
    expect_burst("ovr_burst", 32'h200);
    capture_all("ovr_cap", 1);

    // Reset on the 4th burst beat, then a fresh frame.
    fft_ready = 1'b1;
    fill_frame(32'h300);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      fft_ready = 1'b0;
      chk($sformatf("mid_data%0d", k), {fft_sink_valid, 14'd0, fft_sink_data}, {1'b1, 14'd0, W'(32'h300 + k + 1)});
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_outs("mid_reset", '0);
    fill_frame(32'h400);
    tick();
    expect_burst("mid_fresh", 32'h400);
    capture_all("mid_cap", 0);

    // Randomized traffic against the frame-level model.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    model_on = 1;
    for (int i = 0; i < 800; i++) begin
      sample_strobe    = ($urandom_range(0, 99) < 55);
      sample_in        = W'($urandom);
      fft_ready        = ($urandom_range(0, 99) < 30);
      fft_source_valid = ($urandom_range(0, 99) < 60);
      clear_overrun    = ($urandom_range(0, 99) < 4);
      tick();
      chk_outs($sformatf("rand[%0d]", i), m_exp);
    end
    model_on = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
